// File: rtl/matmul_rd_sched_if.sv
// ---------------------------------------------------------------------------
// matmul_rd_sched_if
// Bundle between the matrix-multiply read scheduler and its surroundings
// (start/done handshake, RAM_A/RAM_B read addresses, MAC control, result
// write strobe).
//
// Modports:
//   master : the scheduler. Drives busy/done, the four read addresses,
//            rd_en, mac_en/mac_first and res_we/res_addr. Samples start
//            (and pause when MATMUL_RD_SCHED_PAUSE_EN is defined).
//   slave  : the surrounding control/datapath. Drives start (and pause),
//            observes everything else.
//
// Optional feature macro: MATMUL_RD_SCHED_PAUSE_EN adds the pause signal.
// ADDR_W must match the scheduler's ADDR_W parameter.
// ---------------------------------------------------------------------------
interface matmul_rd_sched_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr1;
  logic [ADDR_W-1:0] a_addr2;
  logic [ADDR_W-1:0] b_addr1;
  logic [ADDR_W-1:0] b_addr2;
  logic              mac_en;
  logic              mac_first;
  logic              res_we;
  logic [ADDR_W-1:0] res_addr;
`ifdef MATMUL_RD_SCHED_PAUSE_EN
  logic              pause;
`endif

  modport master (
`ifdef MATMUL_RD_SCHED_PAUSE_EN
    input  pause,
`endif
    input  start,
    output busy, done, rd_en,
    output a_addr1, a_addr2, b_addr1, b_addr2,
    output mac_en, mac_first, res_we, res_addr
  );

  modport slave (
`ifdef MATMUL_RD_SCHED_PAUSE_EN
    output pause,
`endif
    output start,
    input  busy, done, rd_en,
    input  a_addr1, a_addr2, b_addr1, b_addr2,
    input  mac_en, mac_first, res_we, res_addr
  );
endinterface

// File: rtl/matmul_rd_sched.sv
// ---------------------------------------------------------------------------
// matmul_rd_sched
// Sequences an NxN x NxN matrix multiply over two dual-read-port operand
// RAMs, two k-terms per cycle. Loop order: k (step 2) innermost, then j,
// then i. For each pair it issues A[i][k], A[i][k+1], B[k][j], B[k+1][j],
// tags the pair so the MAC knows when to restart its sum (k==0), and emits
// a result write one cycle after the MAC consumes the k==N-2 pair.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (drops in-flight pairs)
//   bus   : matmul_rd_sched_if.master -- start/busy/done handshake,
//           rd_en + A/B address pairs, mac_en/mac_first, res_we/res_addr
//
// Parameters: N (even power of two, 2..16), ADDR_W (address width),
//             RD_LAT (RAM read latency, >= 1).
//
// Optional feature macro: MATMUL_RD_SCHED_PAUSE_EN. When defined, bus.pause
// high during ISSUE stalls address issue (rd_en low, i/j/k and addresses
// held); pairs already issued keep flowing to the MAC and result write.
// ---------------------------------------------------------------------------
module matmul_rd_sched #(
  parameter int N      = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  matmul_rd_sched_if.master bus
);

  localparam int CW = $clog2(N);
  localparam int DW = $clog2(RD_LAT + 1) + 1;
  localparam logic [CW-1:0] IDX_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] K_LAST     = CW'(N - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT);

  // Elaboration-time parameter checks.
  generate
    if (N < 2 || N > 16 || (N % 2) != 0 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("matmul_rd_sched: N must be an even power of two in 2..16");
    end
    if ((N * N - 1) >= (1 << ADDR_W)) begin : g_bad_addr_w
      $error("matmul_rd_sched: ADDR_W too small to hold N*N-1");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
      $error("matmul_rd_sched: RD_LAT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     i_q, j_q, k_q;
  logic [CW-1:0]     i_d, j_d, k_d;
  logic              issue_q;
  logic              busy_q;
  logic              done_q;
  logic [DW-1:0]     drain_q;
  logic [ADDR_W-1:0] a1_q, a2_q, b1_q, b2_q;
  logic              last_pair;
  logic              issue_fire;

  // Delay pipe: stage s holds what was issued s+1 cycles ago.
  logic [RD_LAT-1:0]             pv_q;  // pair valid
  logic [RD_LAT-1:0]             pf_q;  // pair valid and k==0
  logic [RD_LAT:0]               pl_q;  // pair valid and k==N-2
  logic [RD_LAT:0][ADDR_W-1:0]   pa_q;  // i*N+j of the pair

  // row*N+col computed entirely in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] rc_addr(input logic [CW-1:0] row,
                                                input logic [CW-1:0] col);
    return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
  endfunction

  // i/j/k always hold the pair currently presented on the address outputs.
  assign last_pair = (i_q == IDX_LAST) && (j_q == IDX_LAST) && (k_q == K_LAST);

`ifdef MATMUL_RD_SCHED_PAUSE_EN
  assign issue_fire = issue_q & ~bus.pause;
`else
  assign issue_fire = issue_q;
`endif

  // Successor of the presented pair; wraps naturally since N is a power of 2.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q + CW'(2);
    if (k_q == K_LAST) begin
      k_d = '0;
      if (j_q == IDX_LAST) begin
        j_d = '0;
        i_d = i_q + CW'(1);
      end else begin
        j_d = j_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drain_q <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // Present pair (0,0,0) in the very next cycle.
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
            issue_q <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a1_q    <= '0;
            a2_q    <= ADDR_W'(1);
            b1_q    <= '0;
            b2_q    <= ADDR_W'(N);
          end
        end
        S_ISSUE: begin
          if (issue_fire) begin
            if (last_pair) begin
              // Addresses stay on the final pair; counters rewind.
              issue_q <= 1'b0;
              state_q <= S_DRAIN;
              drain_q <= '0;
              i_q     <= '0;
              j_q     <= '0;
              k_q     <= '0;
            end else begin
              i_q  <= i_d;
              j_q  <= j_d;
              k_q  <= k_d;
              a1_q <= rc_addr(i_d, k_d);
              a2_q <= rc_addr(i_d, k_d) + ADDR_W'(1);
              b1_q <= rc_addr(k_d, j_d);
              b2_q <= rc_addr(k_d, j_d) + ADDR_W'(N);
            end
          end
        end
        S_DRAIN: begin
          // RD_LAT cycles for the RAM plus one for the final MAC add.
          drain_q <= drain_q + DW'(1);
          if (drain_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
      pa_q <= '0;
    end else begin
      pv_q[0] <= issue_fire;
      pf_q[0] <= issue_fire & (k_q == '0);
      pl_q[0] <= issue_fire & (k_q == K_LAST);
      pa_q[0] <= rc_addr(i_q, j_q);
      for (int s = 1; s < RD_LAT; s++) begin
        pv_q[s] <= pv_q[s-1];
        pf_q[s] <= pf_q[s-1];
      end
      for (int s = 1; s <= RD_LAT; s++) begin
        pl_q[s] <= pl_q[s-1];
        pa_q[s] <= pa_q[s-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = issue_fire;
  assign bus.a_addr1   = a1_q;
  assign bus.a_addr2   = a2_q;
  assign bus.b_addr1   = b1_q;
  assign bus.b_addr2   = b2_q;
  assign bus.mac_en    = pv_q[RD_LAT-1];
  assign bus.mac_first = pf_q[RD_LAT-1];
  assign bus.res_we    = pl_q[RD_LAT];
  assign bus.res_addr  = pa_q[RD_LAT];

endmodule

// File: tb/tb_matmul_rd_sched.sv
module tb_matmul_rd_sched;
  localparam int N      = 8;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;
  localparam int TOTAL  = N * N * N / 2;
  localparam int MAXC   = 8192;
`ifdef MATMUL_RD_SCHED_PAUSE_EN
  localparam int SHIFT1 = 5;
`else
  localparam int SHIFT1 = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  matmul_rd_sched_if #(.ADDR_W(ADDR_W)) bus ();

  matmul_rd_sched #(.N(N), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pair p in issue order: k innermost (step 2), then j, then i.
  function automatic int p_i(input int p); return p / (N * N / 2); endfunction
  function automatic int p_j(input int p); return (p / (N / 2)) % N; endfunction
  function automatic int p_k(input int p); return 2 * (p % (N / 2)); endfunction

  // ---------------- RAM + MAC models ----------------
  logic [15:0] ram_a [256];
  logic [15:0] ram_b [256];
  logic [15:0] ra1, ra2, rb1, rb2;
  logic [31:0] acc;
  logic [31:0] c_mem [256];
  int          c_gen [256];
  int          gen = 0;

  always @(posedge clk) begin
    ra1 <= ram_a[bus.a_addr1];
    ra2 <= ram_a[bus.a_addr2];
    rb1 <= ram_b[bus.b_addr1];
    rb2 <= ram_b[bus.b_addr2];
    if (bus.mac_en === 1'b1)
      acc <= (bus.mac_first ? 32'd0 : acc) + 32'(ra1) * 32'(rb1) + 32'(ra2) * 32'(rb2);
    if (bus.res_we === 1'b1) begin
      c_mem[bus.res_addr] <= acc;
      c_gen[bus.res_addr] <= gen;
    end
  end

  // ---------------- behavioural model + compare ----------------
  bit m_valid = 0, m_busy = 0, m_issuing = 0;
  int m_issued = 0, m_done_cyc = -1, m_addr_p = -1;
  bit hist_fire [MAXC];
  int hist_pair [MAXC];
  int done_pulses = 0;
  // per-run recorders of DUT behaviour, reset at each accepted start
  int rec_first_rd, rec_rd_n, rec_we_n, rec_last_we, rec_done, rec_order_bad;
  int rec_a [2][4];

  always @(negedge clk) begin
    bit e_rd, e_mac, e_first, e_we, pz, accept;
    int src, p, ea1, ea2, eb1, eb2, era;
`ifdef MATMUL_RD_SCHED_PAUSE_EN
    pz = (bus.pause === 1'b1);
`else
    pz = 1'b0;
`endif
    e_rd = 0;
    if (bus.done === 1'b1) done_pulses++;
    if (m_valid) begin
      e_rd = m_issuing && !pz;
      ea1 = 0; ea2 = 0; eb1 = 0; eb2 = 0;
      if (m_addr_p >= 0) begin
        p = m_addr_p;
        ea1 = p_i(p) * N + p_k(p); ea2 = ea1 + 1;
        eb1 = p_k(p) * N + p_j(p); eb2 = eb1 + N;
      end
      src = cyc - RD_LAT;
      e_mac = (src >= 0) && hist_fire[src];
      e_first = e_mac && (p_k(hist_pair[src]) == 0);
      src = cyc - RD_LAT - 1;
      e_we = (src >= 0) && hist_fire[src] && (p_k(hist_pair[src]) == N - 2);
      era = e_we ? p_i(hist_pair[src]) * N + p_j(hist_pair[src]) : 0;
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(cyc == m_done_cyc));
      chk("rd_en", 32'(bus.rd_en), 32'(e_rd));
      chk("a_addr1", 32'(bus.a_addr1), ea1);
      chk("a_addr2", 32'(bus.a_addr2), ea2);
      chk("b_addr1", 32'(bus.b_addr1), eb1);
      chk("b_addr2", 32'(bus.b_addr2), eb2);
      chk("mac_en", 32'(bus.mac_en), 32'(e_mac));
      chk("mac_first", 32'(bus.mac_first), 32'(e_first));
      chk("res_we", 32'(bus.res_we), 32'(e_we));
      if (e_we || m_addr_p < 0) chk("res_addr", 32'(bus.res_addr), era);
      // recorders
      if (bus.rd_en === 1'b1) begin
        if (rec_rd_n == 0) rec_first_rd = cyc;
        if (rec_rd_n < 2) begin
          rec_a[rec_rd_n][0] = int'(bus.a_addr1); rec_a[rec_rd_n][1] = int'(bus.a_addr2);
          rec_a[rec_rd_n][2] = int'(bus.b_addr1); rec_a[rec_rd_n][3] = int'(bus.b_addr2);
        end
        rec_rd_n++;
      end
      if (bus.res_we === 1'b1) begin
        if (int'(bus.res_addr) != rec_we_n) rec_order_bad++;
        rec_we_n++;
        rec_last_we = cyc;
      end
      if (bus.done === 1'b1) rec_done = cyc;
    end
    // model step on what the coming edge samples
    if (reset) begin
      m_valid = 1; m_busy = 0; m_issuing = 0; m_issued = 0;
      m_done_cyc = -1; m_addr_p = -1;
      for (int d = 0; d <= RD_LAT; d++) if (cyc - d >= 0) hist_fire[cyc - d] = 0;
    end else if (m_valid && cyc < MAXC) begin
      hist_fire[cyc] = e_rd;
      hist_pair[cyc] = m_issued;
      accept = !m_busy && (bus.start === 1'b1);
      if (e_rd) begin
        if (m_issued == TOTAL - 1) begin
          m_issuing = 0;
          m_done_cyc = cyc + RD_LAT + 2;
        end else begin
          m_addr_p++;
        end
        m_issued++;
      end
      if (cyc == m_done_cyc) m_busy = 0;
      if (accept) begin
        m_busy = 1; m_issuing = 1; m_issued = 0; m_addr_p = 0;
        rec_rd_n = 0; rec_we_n = 0; rec_order_bad = 0;
        rec_first_rd = -1; rec_last_we = -1; rec_done = -1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_b();
    int boff;
    gen++;
    boff = $urandom_range(0, 200);
    for (int x = 0; x < 256; x++) begin
      ram_a[x] = (x < N * N && (x / N) == (x % N)) ? 16'd1 : 16'd0;
      ram_b[x] = (x < N * N) ? 16'(x * 3 + boff) : 16'd0;
    end
  endtask

  task automatic check_c();
    repeat (3) tick();
    for (int x = 0; x < N * N; x++)
      chk("c_elem", (c_gen[x] == gen) ? c_mem[x] : 32'hFFFF_FFFF, 32'(ram_b[x]));
  endtask

  task automatic run_full(input int pmode, input bit pin, input int shift);
    int t, d0;
    load_b();
    d0 = done_pulses;
    bus.start = 1'b1;
    t = cyc;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 3000 && done_pulses == d0; n++) begin
      bus.start = (cyc == t + 50) || ($urandom_range(0, 15) == 0);
`ifdef MATMUL_RD_SCHED_PAUSE_EN
      bus.pause = (pmode == 1) ? (cyc >= t + 10 && cyc <= t + 14) :
                  (pmode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
`endif
      tick();
    end
    bus.start = 1'b0;
`ifdef MATMUL_RD_SCHED_PAUSE_EN
    bus.pause = 1'b0;
`endif
    chk("done_seen", done_pulses - d0, 1);
    if (pin) begin
      chk("first_rd_lat", rec_first_rd - t, 1);
      chk("p0_a1", rec_a[0][0], 0);  chk("p0_a2", rec_a[0][1], 1);
      chk("p0_b1", rec_a[0][2], 0);  chk("p0_b2", rec_a[0][3], 8);
      chk("p1_a1", rec_a[1][0], 2);  chk("p1_a2", rec_a[1][1], 3);
      chk("p1_b1", rec_a[1][2], 16); chk("p1_b2", rec_a[1][3], 24);
      chk("rd_count", rec_rd_n, 256);
      chk("we_count", rec_we_n, 64);
      chk("we_order_bad", rec_order_bad, 0);
      chk("last_we_time", rec_last_we - t, 258 + shift);
      chk("done_time", rec_done - t, 259 + shift);
    end
    check_c();
  endtask

  initial begin
    int t, d0;
    bus.start = 1'b0;
`ifdef MATMUL_RD_SCHED_PAUSE_EN
    bus.pause = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_rd_en", 32'(bus.rd_en), 0);
    chk("idle_done", 32'(bus.done), 0);

    // run 1: full run, start re-pulsed while busy, pinned timing
    run_full(1, 1'b1, SHIFT1);
    repeat ($urandom_range(1, 6)) tick();

    // run 2: reset at t+100
    load_b();
    bus.start = 1'b1;
    t = cyc;
    tick();
    bus.start = 1'b0;
    while (cyc < t + 100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_mac_en", 32'(bus.mac_en), 0);
    chk("rst_res_we", 32'(bus.res_we), 0);
    chk("rst_a_addr2", 32'(bus.a_addr2), 0);
    chk("rst_b_addr2", 32'(bus.b_addr2), 0);
    repeat (6) tick();

    // run 3: complete run after the aborted one
    run_full(0, 1'b1, 0);
    repeat ($urandom_range(1, 6)) tick();

    // run 4: start held high across done -> two back-to-back runs
    load_b();
    d0 = done_pulses;
    bus.start = 1'b1;
    for (int n = 0; n < 3000 && done_pulses < d0 + 2; n++) begin
`ifdef MATMUL_RD_SCHED_PAUSE_EN
      bus.pause = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    bus.start = 1'b0;
`ifdef MATMUL_RD_SCHED_PAUSE_EN
    bus.pause = 1'b0;
`endif
    chk("held_start_runs", done_pulses - d0, 2);
    check_c();

    // run 5: randomized pause (when present) and random start noise
    run_full(2, 1'b0, 0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
